// File: rtl/fetch_unit.sv
// Purpose : owns the PC, reads a synchronous instruction ROM and holds a registered Instr for the CPU FSM.
// Latency : Instr valid 2 edges after reset release or after an accepted PCEn (FETCH, LOAD, then READY).
// Backpr. : PCEn is only honoured in READY; pulses seen in FETCH or LOAD are dropped. Option macro: FETCH_BRANCH_EN.
module fetch_unit #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              PCEn,
    input  logic [4:0]        ALUFlags,
    input  logic [15:0]       JumpTarget,
    input  logic [15:0]       MemData,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic [15:0]       Instr,
    output logic              IValid,
    output logic [3:0]        JumpReg,
    output logic [15:0]       LinkAddr
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic              ivalid_q, ivalid_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_pc;

    // Flags and jump target are not needed in every build; fold them into a sink.
    logic unused_inputs;
    assign unused_inputs = ^{ALUFlags, JumpTarget};

    assign pc_inc    = pc_q + ADDR_W'(1);
    assign InstrAddr = pc_q;
    assign Instr     = instr_q;
    assign IValid    = ivalid_q;
    assign LinkAddr  = 16'(pc_inc);

`ifdef FETCH_BRANCH_EN
    logic              cond_true;
    logic [ADDR_W-1:0] br_target;
    logic              is_bcond;
    logic              is_jcond;
    logic              is_jal;

    assign JumpReg   = instr_q[3:0];
    assign br_target = pc_q + ADDR_W'($signed(instr_q[7:0]));
    assign is_bcond  = (instr_q[15:12] == 4'b1100);
    assign is_jcond  = (instr_q[15:12] == 4'b0100) && (instr_q[7:4] == 4'b1100);
    assign is_jal    = (instr_q[15:12] == 4'b0100) && (instr_q[7:4] == 4'b1000);

    // Decode the condition field against the PSR flags {C,L,F,Z,N}.
    always_comb begin
        cond_true = 1'b0;
        unique case (instr_q[11:8])
            4'b0000: cond_true =  ALUFlags[1];
            4'b0001: cond_true = ~ALUFlags[1];
            4'b0010: cond_true =  ALUFlags[4];
            4'b0011: cond_true = ~ALUFlags[4];
            4'b0100: cond_true =  ALUFlags[3];
            4'b0101: cond_true = ~ALUFlags[3];
            4'b0110: cond_true =  ALUFlags[0];
            4'b0111: cond_true = ~ALUFlags[0];
            4'b1000: cond_true =  ALUFlags[2];
            4'b1001: cond_true = ~ALUFlags[2];
            4'b1010: cond_true = ~ALUFlags[3] & ~ALUFlags[1];
            4'b1011: cond_true =  ALUFlags[3] |  ALUFlags[1];
            4'b1100: cond_true = ~ALUFlags[0] & ~ALUFlags[1];
            4'b1101: cond_true =  ALUFlags[0] |  ALUFlags[1];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Pick the redirect target; anything that is not a taken branch falls through.
    always_comb begin
        next_pc = pc_inc;
        if (is_bcond && cond_true) begin
            next_pc = br_target;
        end else if (is_jcond && cond_true) begin
            next_pc = JumpTarget[ADDR_W-1:0];
        end else if (is_jal) begin
            next_pc = JumpTarget[ADDR_W-1:0];
        end
    end
`else
    assign JumpReg = 4'h0;

    // Without redirection the PC only ever walks forward.
    always_comb begin
        next_pc = pc_inc;
    end
`endif

    // Fetch sequencing: present address, capture ROM word, then wait for the FSM.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ivalid_d = ivalid_q;
        unique case (state_q)
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                instr_d  = MemData;
                ivalid_d = 1'b1;
                state_d  = READY;
            end
            READY: begin
                if (PCEn) begin
                    pc_d     = next_pc;
                    ivalid_d = 1'b0;
                    state_d  = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State registers; reset discards any in-flight ROM word.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= 16'h0000;
            ivalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : directed checks of fetch_unit sequencing, redirection and PC wrap.
// Latency : ROM model answers one edge after the address is sampled.
// Backpr. : PCEn pulses are driven only where a check wants them.
module tb_fetch_unit;

    logic        Clk;
    logic        Reset_n;
    logic        PCEn;
    logic [4:0]  ALUFlags;
    logic [15:0] JumpTarget;
    logic [15:0] MemData;
    logic [15:0] InstrAddr;
    logic [15:0] Instr;
    logic        IValid;
    logic [3:0]  JumpReg;
    logic [15:0] LinkAddr;

    logic        PCEn_w;
    logic [15:0] MemData_w;
    logic [15:0] InstrAddr_w;
    logic [15:0] Instr_w;
    logic        IValid_w;
    logic [3:0]  JumpReg_w;
    logic [15:0] LinkAddr_w;

    logic [15:0] rom [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .PCEn(PCEn), .ALUFlags(ALUFlags),
        .JumpTarget(JumpTarget), .MemData(MemData), .InstrAddr(InstrAddr),
        .Instr(Instr), .IValid(IValid), .JumpReg(JumpReg), .LinkAddr(LinkAddr)
    );

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_wrap (
        .Clk(Clk), .Reset_n(Reset_n), .PCEn(PCEn_w), .ALUFlags(ALUFlags),
        .JumpTarget(JumpTarget), .MemData(MemData_w), .InstrAddr(InstrAddr_w),
        .Instr(Instr_w), .IValid(IValid_w), .JumpReg(JumpReg_w), .LinkAddr(LinkAddr_w)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous ROMs: one edge from address to data.
    always @(posedge Clk) begin
        MemData   <= rom[InstrAddr];
        MemData_w <= rom[InstrAddr_w];
    end

    function automatic logic [15:0] fill(input logic [15:0] a);
        if (a == 16'h0000) return 16'h5103;
        return {4'h5, a[11:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        PCEn    = 1'b0;
        PCEn_w  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!IValid && n < 8) begin
            tick();
            n++;
        end
        if (!IValid) check({name, "_timeout"}, 32'(IValid), 32'd1);
    endtask

    task automatic pulse();
        PCEn = 1'b1;
        tick();
        PCEn = 1'b0;
    endtask

    task automatic advance_to(input logic [15:0] pc);
        int guard;
        guard = 0;
        wait_ready("adv");
        while (InstrAddr != pc && guard < 64) begin
            pulse();
            wait_ready("adv");
            guard++;
        end
        if (InstrAddr != pc) check("adv_reach", 32'(InstrAddr), 32'(pc));
    endtask

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [4:0]  flags;
        logic [15:0] jt;
        logic [15:0] exp_br;
        logic [15:0] exp_nb;
        logic [3:0]  jr;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [15:0] exp_pc;
        logic [3:0]  exp_jr;

        for (int a = 0; a < 65536; a++) rom[a] = fill(16'(a));
        Reset_n    = 1'b0;
        PCEn       = 1'b0;
        PCEn_w     = 1'b0;
        ALUFlags   = 5'b0;
        JumpTarget = 16'h0;

        //          name        pc      instr     flags     jt        br        nb        jr
        vecs[0]  = '{"beq_t",   16'd5,  16'hC0FE, 5'b00010, 16'h0000, 16'h0003, 16'h0006, 4'hE};
        vecs[1]  = '{"beq_nt",  16'd5,  16'hC0FE, 5'b00000, 16'h0000, 16'h0006, 16'h0006, 4'hE};
        vecs[2]  = '{"juc",     16'd2,  16'h4EC7, 5'b00000, 16'h0040, 16'h0040, 16'h0003, 4'h7};
        vecs[3]  = '{"jal",     16'd9,  16'h4F87, 5'b00000, 16'h1234, 16'h1234, 16'h000A, 4'h7};
        vecs[4]  = '{"bne_t",   16'd3,  16'hC102, 5'b00000, 16'h0000, 16'h0005, 16'h0004, 4'h2};
        vecs[5]  = '{"bgt_bk",  16'd4,  16'hC6FC, 5'b00001, 16'h0000, 16'h0000, 16'h0005, 4'hC};
        vecs[6]  = '{"jhs_nt",  16'd1,  16'h4BC3, 5'b00000, 16'h0100, 16'h0002, 16'h0002, 4'h3};
        vecs[7]  = '{"jlo_t",   16'd1,  16'h4AC3, 5'b00000, 16'h0100, 16'h0100, 16'h0002, 4'h3};
        vecs[8]  = '{"bnever",  16'd2,  16'hCF05, 5'b11111, 16'h0000, 16'h0003, 16'h0003, 4'h5};
        vecs[9]  = '{"buc_fwd", 16'd3,  16'hCE7F, 5'b00000, 16'h0000, 16'h0082, 16'h0004, 4'hF};
        vecs[10] = '{"jal_z0",  16'd0,  16'h4085, 5'b00000, 16'h0ABC, 16'h0ABC, 16'h0001, 4'h5};
        vecs[11] = '{"bfs_self",16'd2,  16'hC800, 5'b00100, 16'h0000, 16'h0002, 16'h0003, 4'h0};
        vecs[12] = '{"jlt_t",   16'd1,  16'h4CC3, 5'b10000, 16'h0077, 16'h0077, 16'h0002, 4'h3};
        vecs[13] = '{"addi",    16'd1,  16'h5103, 5'b00010, 16'h0300, 16'h0002, 16'h0002, 4'h3};
        vecs[14] = '{"buc_wrap",16'd1,  16'hCEF0, 5'b00000, 16'h0000, 16'hFFF1, 16'h0002, 4'h0};

        // Reset state and first-fetch latency.
        repeat (2) @(posedge Clk);
        #1;
        check("rst_addr",  32'(InstrAddr), 32'h0);
        check("rst_valid", 32'(IValid),    32'h0);
        check("rst_instr", 32'(Instr),     32'h0);
        check("rst_link",  32'(LinkAddr),  32'h1);
        check("rst_jr",    32'(JumpReg),   32'h0);
        Reset_n = 1'b1;
        tick();
        check("first_e1_valid", 32'(IValid), 32'h0);
        tick();
        check("first_e2_valid", 32'(IValid), 32'h1);
        check("first_e2_instr", 32'(Instr),  32'h5103);

        // Sequential advance, with PCEn asserted through FETCH and LOAD.
        pulse();
        check("adv_valid_drop", 32'(IValid),    32'h0);
        check("adv_addr",       32'(InstrAddr), 32'h1);
        PCEn = 1'b1;
        tick();
        check("load_ign_addr", 32'(InstrAddr), 32'h1);
        tick();
        PCEn = 1'b0;
        check("load_ign_addr2", 32'(InstrAddr), 32'h1);
        check("load_ign_valid", 32'(IValid),    32'h1);
        check("load_ign_instr", 32'(Instr),     32'(rom[1]));

        // PCEn held high: one acceptance per READY entry.
        PCEn = 1'b1;
        tick();
        check("hold_a1_addr", 32'(InstrAddr), 32'h2);
        tick();
        tick();
        check("hold_rdy_addr",  32'(InstrAddr), 32'h2);
        check("hold_rdy_valid", 32'(IValid),    32'h1);
        tick();
        PCEn = 1'b0;
        check("hold_a2_addr",  32'(InstrAddr), 32'h3);
        check("hold_a2_valid", 32'(IValid),    32'h0);

        // Asynchronous reset in the middle of LOAD.
        wait_ready("mid");
        pulse();
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        check("midrst_addr",  32'(InstrAddr), 32'h0);
        check("midrst_valid", 32'(IValid),    32'h0);
        check("midrst_instr", 32'(Instr),     32'h0);
        tick();
        check("midrst_hold_valid", 32'(IValid), 32'h0);
        Reset_n = 1'b1;
        tick();
        check("midrst_e1_valid", 32'(IValid), 32'h0);
        tick();
        check("midrst_e2_valid", 32'(IValid), 32'h1);
        check("midrst_e2_instr", 32'(Instr),  32'h5103);

        // PC wrap from all-ones on the second instance.
        do_reset();
        begin
            int n;
            n = 0;
            while (!IValid_w && n < 8) begin
                tick();
                n++;
            end
        end
        check("wrap_ready", 32'(IValid_w),    32'h1);
        check("wrap_addr",  32'(InstrAddr_w), 32'hFFFF);
        check("wrap_link",  32'(LinkAddr_w),  32'h0);
        check("wrap_instr", 32'(Instr_w),     32'h5FFF);
        PCEn_w = 1'b1;
        tick();
        PCEn_w = 1'b0;
        check("wrap_next_addr", 32'(InstrAddr_w), 32'h0);
        tick();
        tick();
        check("wrap_next_instr", 32'(Instr_w), 32'h5103);

        // Redirection table.
        for (int i = 0; i < 15; i++) begin
`ifdef FETCH_BRANCH_EN
            exp_pc = vecs[i].exp_br;
            exp_jr = vecs[i].jr;
`else
            exp_pc = vecs[i].exp_nb;
            exp_jr = 4'h0;
`endif
            rom[vecs[i].pc] = vecs[i].instr;
            do_reset();
            advance_to(vecs[i].pc);
            ALUFlags   = vecs[i].flags;
            JumpTarget = vecs[i].jt;
            #1;
            check({vecs[i].name, "_instr"}, 32'(Instr),    32'(vecs[i].instr));
            check({vecs[i].name, "_link"},  32'(LinkAddr), 32'(vecs[i].pc + 16'd1));
            check({vecs[i].name, "_jr"},    32'(JumpReg),  32'(exp_jr));
            pulse();
            ALUFlags   = 5'b0;
            JumpTarget = 16'h0;
            check({vecs[i].name, "_pc"},    32'(InstrAddr), 32'(exp_pc));
            check({vecs[i].name, "_v0"},    32'(IValid),    32'h0);
            tick();
            check({vecs[i].name, "_v1"},    32'(IValid),    32'h0);
            tick();
            check({vecs[i].name, "_v2"},    32'(IValid),    32'h1);
            check({vecs[i].name, "_fetch"}, 32'(Instr),     32'(rom[exp_pc]));
            rom[vecs[i].pc] = fill(vecs[i].pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the CPU control FSM. It owns the program counter, reads a synchronous instruction ROM, and presents a stable registered `Instr` to the FSM. When the FSM pulses `PCEn`, the unit advances the PC to the next sequential address or to a resolved Bcond/Jcond/JAL target, then fetches the next word. PC is word-addressed: one 16-bit instruction per address.

## Interface
- `ADDR_W`, default 16: PC and instruction-address width.
- `RESET_PC`, default 0: PC value loaded on reset.

- `Clk`  in  1  system clock; all state updates on rising edge.
- `Reset_n`  in  1  asynchronous active-low reset.
- `PCEn`  in  1  from CPU FSM; one-cycle pulse meaning the current `Instr` is consumed and the PC must advance.
- `ALUFlags`  in  5  PSR flags {C,L,F,Z,N} = bits [4:0], MSB first; sampled on the `PCEn` edge.
- `JumpTarget`  in  16  register-file read of `JumpReg`; target for Jcond/JAL.
- `MemData`  in  16  ROM read data, valid one cycle after the ROM samples `InstrAddr`.
- `InstrAddr`  out  ADDR_W  registered ROM address; equals PC.
- `Instr`  out  16  registered instruction fed to the CPU FSM.
- `IValid`  out  1  `Instr` holds the word at the current PC.
- `JumpReg`  out  4  `Instr[3:0]`, the Rtarget index for the register-file read port.
- `LinkAddr`  out  16  PC+1, zero-extended; the JAL writeback value.

## Operation
- Reset (async, `Reset_n`=0):
  - PC=`RESET_PC`, `Instr`=16'h0000, `IValid`=0, state=FETCH.
  - `LinkAddr`=`RESET_PC`+1 and `JumpReg`=0 follow combinationally.
- States:
  - FETCH: `InstrAddr`=PC is stable; ROM samples it at the end edge. Next state is LOAD.
  - LOAD: `MemData` is valid. At the end edge, `Instr`<=`MemData` and `IValid`<=1. Next state is READY.
  - READY: hold `Instr` and PC. On an edge with `PCEn`=1: PC<=next_pc, `IValid`<=0, next state is FETCH. Otherwise stay in READY.
- `PCEn` in FETCH or LOAD is ignored: no PC change and no error.
- next_pc rules, evaluated on `Instr` and `ALUFlags` at the `PCEn` edge:
  - Bcond (`Instr[15:12]`=4'b1100): if cond(`Instr[11:8]`) is true, PC + sext(`Instr[7:0]`); else PC+1.
  - Jcond (`Instr[15:12]`=4'b0100 and `Instr[7:4]`=4'b1100): if cond(`Instr[11:8]`) is true, `JumpTarget[ADDR_W-1:0]`; else PC+1.
  - JAL (`Instr[15:12]`=4'b0100 and `Instr[7:4]`=4'b1000): unconditionally `JumpTarget[ADDR_W-1:0]`.
  - All other encodings: PC+1.
- Condition codes:
  - 0000 EQ: Z=1. 0001 NE: Z=0.
  - 0010 CS: C=1. 0011 CC: C=0.
  - 0100 HI: L=1. 0101 LS: L=0.
  - 0110 GT: N=1. 0111 LE: N=0.
  - 1000 FS: F=1. 1001 FC: F=0.
  - 1010 LO: L=0 and Z=0. 1011 HS: L=1 or Z=1.
  - 1100 LT: N=0 and Z=0. 1101 GE: N=1 or Z=1.
  - 1110 UC: always true. 1111: never true.
- Arithmetic:
  - All PC math is modulo 2^ADDR_W. PC all-ones +1 wraps to 0.
  - Branch displacement is sign-extended to ADDR_W, so backward and forward targets wrap.
  - `LinkAddr` is PC+1 computed the same way.
- JAL writeback into the register file is the FSM's job; this block only supplies `LinkAddr`.

## Timing
- First valid instruction: `IValid` rises on the 2nd rising edge after `Reset_n` deasserts.
- `PCEn` edge to next `IValid`=1: exactly 2 clock edges (FETCH then LOAD).
- `Instr` changes only on the LOAD→READY edge and on reset; it is stable for the whole READY interval.
- Flags and `JumpTarget` must be settled before the `PCEn` edge. They are not sampled anywhere else.
- Reset asserted mid-fetch: state returns to FETCH immediately, and any in-flight `MemData` is discarded.
- `PCEn` held high across several cycles: accepted once on entry into READY; later cycles are ignored until the next READY.

## Configuration
- `FETCH_BRANCH_EN` defined:
  - Bcond, Jcond and JAL redirection as specified above.
  - `JumpReg`=`Instr[3:0]`.
- `FETCH_BRANCH_EN` undefined:
  - next_pc is always PC+1.
  - `JumpReg` is tied to 4'h0.
  - `ALUFlags` and `JumpTarget` are unused.
  - `LinkAddr` is still driven.

## Test plan
- Reset with `RESET_PC`=0 and ROM[0]=16'h5103 → `InstrAddr`=0, `IValid`=0 after reset; `IValid`=1 and `Instr`=16'h5103 on the 2nd edge.
- ROM[0]=ADDI, one `PCEn` pulse → `IValid` drops, `InstrAddr`=1, and `Instr`=ROM[1] 2 edges later. A `PCEn` pulse during LOAD is ignored.
- Instr=16'hC0FE (BEQ, disp −2) at PC=5:
  - Z=1 → PC=3.
  - Z=0 → PC=6.
- Instr=16'h4EC7 (JUC r7) with `JumpTarget`=16'h0040 → `JumpReg`=7 and PC=16'h0040. Instr=16'h4F87 (JAL) at PC=9 → `LinkAddr`=10 and PC=`JumpTarget`.
- PC=16'hFFFF with a non-branch instruction, `PCEn` → PC=0. `Reset_n` pulsed low during LOAD → PC=`RESET_PC`, `IValid`=0, state=FETCH.
- Build without `FETCH_BRANCH_EN`: BEQ with Z=1 at PC=5 → PC=6.
